// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO of arbitrary depth with programmable almost-full/almost-empty
// thresholds, fill level, sticky overflow/underflow flags and selectable FWFT/registered read.
module sync_fifo_prog #(
  parameter int    DSIZE       = 8,
  parameter int    DEPTH       = 16,
  parameter string FALLTHROUGH = "FALSE",
  localparam int   LW          = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  output logic             wfull,
  output logic             awfull,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty,
  output logic             arempty,
  output logic [LW-1:0]    level,
  input  logic [LW-1:0]    afull_thresh,
  input  logic [LW-1:0]    aempty_thresh,
  output logic             overflow,
  output logic             underflow,
  input  logic             clr_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam bit FT = (FALLTHROUGH == "TRUE");

  logic [DSIZE-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             wr_ok, rd_ok;

  always_comb begin
    wfull   = (level_q == LW'(DEPTH));
    rempty  = (level_q == '0);
    awfull  = (level_q >= afull_thresh);
    arempty = (level_q <= aempty_thresh);
    level   = level_q;
    overflow  = overflow_q;
    underflow = underflow_q;
  end

  always_comb begin
    wr_ok = winc & ~wfull;
    rd_ok = rinc & ~rempty;
  end

  // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths work.
  always_comb begin
    wptr_d = wptr_q;
    if (wr_ok) begin
      wptr_d = (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + PW'(1);
    end
    rptr_d = rptr_q;
    if (rd_ok) begin
      rptr_d = (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + PW'(1);
    end
  end

  always_comb begin
    level_d = level_q;
    case ({wr_ok, rd_ok})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // A new error in the same cycle as clr_err wins.
  always_comb begin
    overflow_d  = clr_err ? 1'b0 : overflow_q;
    underflow_d = clr_err ? 1'b0 : underflow_q;
    if (winc && wfull) begin
      overflow_d = 1'b1;
    end
    if (rinc && rempty) begin
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && wr_ok) begin
      mem_q[wptr_q] <= wdata;
    end
  end

  generate
    if (FT) begin : g_fwft
      always_comb begin
        rdata = rempty ? '0 : mem_q[rptr_q];
      end
    end else begin : g_reg
      logic [DSIZE-1:0] rdata_q, rdata_d;

      always_comb begin
        rdata_d = rdata_q;
        if (rd_ok) begin
          rdata_d = mem_q[rptr_q];
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          rdata_q <= '0;
        end else begin
          rdata_q <= rdata_d;
        end
      end

      always_comb begin
        rdata = rdata_q;
      end
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed bench for sync_fifo_prog: depth-5 registered, depth-16 thresholds, depth-4 fall-through.
module tb_sync_fifo_prog;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: DEPTH=5, registered read
  logic       a_winc, a_rinc, a_clr;
  logic [7:0] a_wdata, a_rdata;
  logic       a_wfull, a_awfull, a_rempty, a_arempty, a_ovf, a_udf;
  logic [2:0] a_level, a_afull, a_aempty;

  // Instance B: DEPTH=16, registered read, threshold checks
  logic       b_winc, b_rinc, b_clr;
  logic [7:0] b_wdata, b_rdata;
  logic       b_wfull, b_awfull, b_rempty, b_arempty, b_ovf, b_udf;
  logic [4:0] b_level, b_afull, b_aempty;

  // Instance C: DEPTH=4, fall-through
  logic       c_winc, c_rinc, c_clr;
  logic [7:0] c_wdata, c_rdata;
  logic       c_wfull, c_awfull, c_rempty, c_arempty, c_ovf, c_udf;
  logic [2:0] c_level, c_afull, c_aempty;

  sync_fifo_prog #(.DSIZE(8), .DEPTH(5), .FALLTHROUGH("FALSE")) u_a (
    .clk(clk), .rst_n(rst_n), .winc(a_winc), .wdata(a_wdata), .wfull(a_wfull),
    .awfull(a_awfull), .rinc(a_rinc), .rdata(a_rdata), .rempty(a_rempty),
    .arempty(a_arempty), .level(a_level), .afull_thresh(a_afull),
    .aempty_thresh(a_aempty), .overflow(a_ovf), .underflow(a_udf), .clr_err(a_clr)
  );

  sync_fifo_prog #(.DSIZE(8), .DEPTH(16), .FALLTHROUGH("FALSE")) u_b (
    .clk(clk), .rst_n(rst_n), .winc(b_winc), .wdata(b_wdata), .wfull(b_wfull),
    .awfull(b_awfull), .rinc(b_rinc), .rdata(b_rdata), .rempty(b_rempty),
    .arempty(b_arempty), .level(b_level), .afull_thresh(b_afull),
    .aempty_thresh(b_aempty), .overflow(b_ovf), .underflow(b_udf), .clr_err(b_clr)
  );

  sync_fifo_prog #(.DSIZE(8), .DEPTH(4), .FALLTHROUGH("TRUE")) u_c (
    .clk(clk), .rst_n(rst_n), .winc(c_winc), .wdata(c_wdata), .wfull(c_wfull),
    .awfull(c_awfull), .rinc(c_rinc), .rdata(c_rdata), .rempty(c_rempty),
    .arempty(c_arempty), .level(c_level), .afull_thresh(c_afull),
    .aempty_thresh(c_aempty), .overflow(c_ovf), .underflow(c_udf), .clr_err(c_clr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  logic exp_ae [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  logic exp_af [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    rst_n = 1'b0;
    a_winc = 1'b1; a_rinc = 1'b1; a_clr = 1'b0; a_wdata = 8'h00;
    b_winc = 1'b1; b_rinc = 1'b1; b_clr = 1'b0; b_wdata = 8'h00;
    c_winc = 1'b1; c_rinc = 1'b1; c_clr = 1'b0; c_wdata = 8'h00;
    a_afull = 3'd4; a_aempty = 3'd1;
    b_afull = 5'd3; b_aempty = 5'd1;
    c_afull = 3'd3; c_aempty = 3'd0;

    // Reset held two cycles with requests active
    step(); step();
    chk("rst_a_level",  32'(a_level),  32'd0);
    chk("rst_a_rempty", 32'(a_rempty), 32'd1);
    chk("rst_a_wfull",  32'(a_wfull),  32'd0);
    chk("rst_a_awfull", 32'(a_awfull), 32'd0);
    chk("rst_a_arempty",32'(a_arempty),32'd1);
    chk("rst_a_ovf",    32'(a_ovf),    32'd0);
    chk("rst_a_udf",    32'(a_udf),    32'd0);
    chk("rst_a_rdata",  32'(a_rdata),  32'h00);
    chk("rst_c_rdata",  32'(c_rdata),  32'h00);
    rst_n = 1'b1;
    a_winc = 1'b0; a_rinc = 1'b0;
    b_winc = 1'b0; b_rinc = 1'b0;
    c_winc = 1'b0; c_rinc = 1'b0;
    step();

    // A: fill to DEPTH, overflow, drain in order
    a_winc = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a_wdata = 8'(32'hA0 + i);
      step();
    end
    chk("fill_level", 32'(a_level),  32'd5);
    chk("fill_wfull", 32'(a_wfull),  32'd1);
    chk("fill_awfull",32'(a_awfull), 32'd1);
    a_wdata = 8'hEE;
    step();
    chk("ovf_level",  32'(a_level),  32'd5);
    chk("ovf_flag",   32'(a_ovf),    32'd1);
    a_winc = 1'b0;
    a_rinc = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("drain_rdata", 32'(a_rdata), 32'hA0 + 32'(i));
    end
    a_rinc = 1'b0;
    step();
    chk("drain_rempty", 32'(a_rempty), 32'd1);
    chk("drain_level",  32'(a_level),  32'd0);
    chk("drain_hold",   32'(a_rdata),  32'hA4);
    a_rinc = 1'b1;
    step();
    chk("udf_flag",     32'(a_udf),    32'd1);
    chk("udf_rdata",    32'(a_rdata),  32'hA4);
    a_rinc = 1'b0;
    a_clr = 1'b1;
    step();
    a_clr = 1'b0;
    chk("clr_ovf",      32'(a_ovf),    32'd0);
    chk("clr_udf",      32'(a_udf),    32'd0);

    // A: pointer wrap over 4 rounds of 3 writes / 3 reads
    for (int r = 0; r < 4; r++) begin
      a_winc = 1'b1;
      for (int k = 0; k < 3; k++) begin
        a_wdata = 8'(32'h30 + r * 16 + k);
        step();
      end
      a_winc = 1'b0;
      a_rinc = 1'b1;
      for (int k = 0; k < 3; k++) begin
        step();
        chk("wrap_rdata", 32'(a_rdata), 32'h30 + 32'(r * 16 + k));
      end
      a_rinc = 1'b0;
    end
    chk("wrap_level", 32'(a_level), 32'd0);

    // A: simultaneous write+read at level 2, 0 and DEPTH
    a_winc = 1'b1;
    a_wdata = 8'hB0; step();
    a_wdata = 8'hB1; step();
    a_rinc = 1'b1;
    a_wdata = 8'hB2; step();
    chk("sim2_level", 32'(a_level), 32'd2);
    chk("sim2_rdata", 32'(a_rdata), 32'hB0);
    a_winc = 1'b0;
    step();
    chk("sim2_rd1", 32'(a_rdata), 32'hB1);
    step();
    chk("sim2_rd2", 32'(a_rdata), 32'hB2);
    chk("sim2_udf", 32'(a_udf),   32'd0);
    a_winc = 1'b1;
    a_wdata = 8'hC0;
    step();
    chk("sim0_level", 32'(a_level), 32'd1);
    chk("sim0_udf",   32'(a_udf),   32'd1);
    chk("sim0_rdata", 32'(a_rdata), 32'hB2);
    a_winc = 1'b0; a_rinc = 1'b0; a_clr = 1'b1;
    step();
    a_clr = 1'b0;
    a_winc = 1'b1;
    for (int i = 1; i < 5; i++) begin
      a_wdata = 8'(32'hC0 + i);
      step();
    end
    chk("simF_pre", 32'(a_level), 32'd5);
    a_rinc = 1'b1;
    a_wdata = 8'hCF;
    step();
    chk("simF_level", 32'(a_level), 32'd4);
    chk("simF_ovf",   32'(a_ovf),   32'd1);
    chk("simF_rdata", 32'(a_rdata), 32'hC0);
    a_winc = 1'b0;
    for (int i = 1; i < 5; i++) begin
      step();
      chk("simF_drain", 32'(a_rdata), 32'hC0 + 32'(i));
    end
    a_rinc = 1'b0;
    step();
    chk("simF_empty", 32'(a_rempty), 32'd1);

    // B: almost-full/almost-empty thresholds
    chk("thr_ae_0", 32'(b_arempty), 32'(exp_ae[0]));
    chk("thr_af_0", 32'(b_awfull),  32'(exp_af[0]));
    for (int l = 1; l < 4; l++) begin
      b_winc = 1'b1;
      b_wdata = 8'(l);
      step();
      b_winc = 1'b0;
      chk("thr_level", 32'(b_level),   32'(l));
      chk("thr_ae",    32'(b_arempty), 32'(exp_ae[l]));
      chk("thr_af",    32'(b_awfull),  32'(exp_af[l]));
      if (l == 2) begin
        b_afull = 5'd2;
        #1;
        chk("thr_live", 32'(b_awfull), 32'd1);
        b_afull = 5'd3;
        #1;
        chk("thr_back", 32'(b_awfull), 32'd0);
      end
    end
    b_winc = 1'b1;
    for (int i = 0; i < 12; i++) step();
    chk("b_l15_level", 32'(b_level), 32'd15);
    chk("b_l15_wfull", 32'(b_wfull), 32'd0);
    step();
    b_winc = 1'b0;
    chk("b_full_level", 32'(b_level), 32'd16);
    chk("b_full_wfull", 32'(b_wfull), 32'd1);

    // C: fall-through behaviour
    chk("ft_empty_rdata", 32'(c_rdata), 32'h00);
    c_winc = 1'b1;
    c_wdata = 8'h5A;
    step();
    c_winc = 1'b0;
    chk("ft_rempty", 32'(c_rempty), 32'd0);
    chk("ft_rdata",  32'(c_rdata),  32'h5A);
    step();
    chk("ft_hold",   32'(c_rdata),  32'h5A);
    c_rinc = 1'b1;
    step();
    chk("ft_pop_empty", 32'(c_rempty), 32'd1);
    chk("ft_pop_rdata", 32'(c_rdata),  32'h00);
    step();
    chk("ft_udf", 32'(c_udf), 32'd1);
    c_clr = 1'b1;
    step();
    chk("ft_udf_wins", 32'(c_udf), 32'd1);
    c_rinc = 1'b0;
    step();
    c_clr = 1'b0;
    chk("ft_udf_clr", 32'(c_udf), 32'd0);
    c_winc = 1'b1;
    c_wdata = 8'h11; step();
    c_wdata = 8'h22; step();
    c_winc = 1'b0;
    chk("ft_two_head", 32'(c_rdata), 32'h11);
    c_rinc = 1'b1;
    step();
    chk("ft_two_next", 32'(c_rdata), 32'h22);
    c_rinc = 1'b0;

    // C: reset mid-operation discards contents
    c_winc = 1'b1;
    c_wdata = 8'h77;
    step();
    c_winc = 1'b0;
    chk("mid_level", 32'(c_level), 32'd2);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_level",  32'(c_level),  32'd0);
    chk("mid_rst_rempty", 32'(c_rempty), 32'd1);
    chk("mid_rst_rdata",  32'(c_rdata),  32'h00);
    c_winc = 1'b1;
    c_wdata = 8'h99;
    step();
    c_winc = 1'b0;
    chk("mid_new_head", 32'(c_rdata), 32'h99);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
